// File: rtl/demux_pkg.sv
// Channel codes shared by the four-way split and gather blocks.
package demux_pkg;

  typedef logic [1:0] ch_t;

  localparam ch_t CH_A = 2'b00;
  localparam ch_t CH_B = 2'b01;
  localparam ch_t CH_C = 2'b10;
  localparam ch_t CH_D = 2'b11;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way arbiter: round-robin with a registered pointer when MUX_GATHER_RR_EN
// is defined, otherwise combinational fixed priority A > B > C > D.
module rr_arbiter4
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       advance,
  output logic [3:0] grant,
  output ch_t        grant_idx
);

`ifdef MUX_GATHER_RR_EN
  ch_t  ptr;
  ch_t  cand;
  logic found;

  // Search starts at the pointer and wraps through all four channels
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    cand      = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + ch_t'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= CH_A;
    end else if (advance) begin
      ptr <= grant_idx + 2'd1;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^{clk, rst, advance};

  always_comb begin
    grant     = '0;
    grant_idx = CH_A;
    if (req[0]) begin
      grant[0]  = 1'b1;
      grant_idx = CH_A;
    end else if (req[1]) begin
      grant[1]  = 1'b1;
      grant_idx = CH_B;
    end else if (req[2]) begin
      grant[2]  = 1'b1;
      grant_idx = CH_C;
    end else if (req[3]) begin
      grant[3]  = 1'b1;
      grant_idx = CH_D;
    end
  end
`endif

endmodule

// File: rtl/mux_gather.sv
// Four-to-one gathering mux with a single registered output beat and channel tag.
// Arbitration mode selected by MUX_GATHER_RR_EN (round-robin) or fixed priority.
module mux_gather
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] c_data,
  input  logic [DATA_W-1:0] d_data,
  input  logic              a_valid,
  input  logic              b_valid,
  input  logic              c_valid,
  input  logic              d_valid,
  output logic              a_ready,
  output logic              b_ready,
  output logic              c_ready,
  output logic              d_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [3:0]        req;
  logic [3:0]        grant;
  logic [3:0]        rdy;
  ch_t               grant_idx;
  logic              ld;
  logic              accept;
  logic [DATA_W-1:0] din;

  logic [DATA_W-1:0] data_p0;
  ch_t               sel_p0;
  logic              vld_p0;

  assign req    = {d_valid, c_valid, b_valid, a_valid};
  assign ld     = !vld_p0 || out_ready;
  // Readies are forced low during reset so nothing is taken and then dropped
  assign rdy    = grant & {4{ld && !rst}};
  assign accept = |rdy;

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign c_ready = rdy[2];
  assign d_ready = rdy[3];

  rr_arbiter4 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    din = a_data;
    case (grant_idx)
      CH_A: din = a_data;
      CH_B: din = b_data;
      CH_C: din = c_data;
      CH_D: din = d_data;
      default: din = a_data;
    endcase
  end

  // Stage p0: output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= CH_A;
    end else if (ld) begin
      vld_p0 <= accept;
      if (accept) begin
        data_p0 <= din;
        sel_p0  <= grant_idx;
      end
    end
  end

  assign out_data  = data_p0;
  assign out_sel   = sel_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_gather.sv
// Directed bench for mux_gather with a reference arbiter model and a beat scoreboard.
module tb_mux_gather;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data, c_data, d_data;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] sb_q[$];
  logic       m_vld;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  logic [1:0] m_ptr;

  always #5 clk = ~clk;

  mux_gather #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .b_data    (b_data),
    .c_data    (c_data),
    .d_data    (d_data),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .c_valid   (c_valid),
    .d_valid   (d_valid),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .c_ready   (c_ready),
    .d_ready   (d_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_arb(input logic [3:0] v, input logic [1:0] p);
    int k;
`ifdef MUX_GATHER_RR_EN
    for (int i = 0; i < 4; i++) begin
      k = (int'(p) + i) % 4;
      if (v[k]) return k;
    end
`else
    for (int i = 0; i < 4; i++) begin
      k = i;
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic logic [7:0] chan_data(input int k);
    case (k)
      0: return a_data;
      1: return b_data;
      2: return c_data;
      default: return d_data;
    endcase
  endfunction

  // One clock: drive, check at the falling edge, then advance the model
  task automatic cyc(input logic r, input logic [3:0] v, input logic ordy);
    int         g;
    logic       mld;
    logic [3:0] exp_rdy;
    logic [9:0] beat;
    rst = r;
    {d_valid, c_valid, b_valid, a_valid} = v;
    out_ready = ordy;
    @(negedge clk);
    g = model_arb(v, m_ptr);
    mld = !m_vld || ordy;
    exp_rdy = (g >= 0 && mld && !r) ? (4'b0001 << g) : 4'b0000;
    chk("ready", {28'd0, d_ready, c_ready, b_ready, a_ready}, {28'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("out_reg", {22'd0, out_sel, out_data}, {22'd0, m_sel, m_data});
    if (out_valid && ordy) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        beat = sb_q.pop_front();
        chk("sb_beat", {22'd0, out_sel, out_data}, {22'd0, beat});
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_vld = 1'b0; m_data = 8'h00; m_sel = 2'b00; m_ptr = 2'b00;
      sb_q.delete();
    end else if (mld) begin
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_data = chan_data(g);
        m_sel  = 2'(g);
        m_ptr  = 2'((g + 1) % 4);
        sb_q.push_back({m_sel, m_data});
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    a_data = 8'h11; b_data = 8'h22; c_data = 8'h33; d_data = 8'h44;
    {d_valid, c_valid, b_valid, a_valid} = 4'hF;
    m_vld = 1'b0; m_data = 8'h00; m_sel = 2'b00; m_ptr = 2'b00;
    @(posedge clk);
    #1;

    // Reset held with all valids high
    cyc(1'b1, 4'hF, 1'b1);
    cyc(1'b1, 4'hF, 1'b1);

    // Continuous traffic on all channels
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // Single channel C
    c_data = 8'h5A;
    cyc(1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // Backpressure with A and B offering
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0011, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0011, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // Reset while a beat is held
    a_data = 8'hC3;
    cyc(1'b0, 4'b0001, 1'b0);
    cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_gather.md
# mux_gather

Four-to-one gathering multiplexer. It is the collecting end of the four-way data split: four independent 8-bit channels (A, B, C, D) each offer data with a valid/ready handshake, and the block merges them into one registered output stream. Each output beat carries a 2-bit channel tag using the same encoding as the split side's `sel` (00=A, 01=B, 10=C, 11=D), so a downstream splitter can route data back by tag.

## Interface
- `DATA_W`, 8: width of every data channel and of the output data.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_data`, `b_data`, `c_data`, `d_data` in DATA_W: channel payloads.
- `a_valid`, `b_valid`, `c_valid`, `d_valid` in 1: the channel offers a beat.
- `a_ready`, `b_ready`, `c_ready`, `d_ready` out 1: the channel's beat is accepted this cycle.
- `out_data` out DATA_W: registered merged payload.
- `out_sel` out 2: channel tag of `out_data`.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: the consumer takes the beat this cycle.

## Operation
- One output holding register (data, tag, valid). Load enable `ld = !out_valid | out_ready`.
- Arbiter picks one grant among valid channels each cycle. The grant is combinational from the `*_valid` signals and the priority state.
- `x_ready = grant_x & ld`. At most one `*_ready` is high per cycle. Ready never depends on a channel being granted in a previous cycle.
- Accept (`x_valid & x_ready`): next cycle `out_data` = `x_data`, `out_sel` = the channel code, and `out_valid` = 1.
- `out_valid & out_ready` with no accept: next cycle `out_valid` = 0. `out_data` and `out_sel` hold their last values.
- `out_valid & out_ready` with an accept in the same cycle: the register reloads and `out_valid` stays 1. This gives full throughput of one beat per cycle.
- `out_valid & !out_ready`: all outputs hold, all `*_ready` = 0 (backpressure).
- No valid channels: no grant, all ready = 0, and the priority state is unchanged.
- Input-side rule: a channel must hold its data stable while valid and not ready. The block does not check this rule.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 2'b00.
  - All `*_ready` = 0 during the reset cycle (forced low while `rst`).
  - Priority pointer = 0 (A highest).
- Reset mid-operation: any beat held in the output register is dropped. An input accepted in the same cycle as `rst` is also discarded.

## Timing
- Latency is 1 cycle: an accept at edge N gives `out_valid` = 1 after edge N.
- Throughput is 1 beat/cycle while `out_ready` = 1.
- Output is fully registered. The only combinational paths are from `*_valid` and `out_ready` to `*_ready`.
- Priority update (round-robin mode): after an accept from channel k, the pointer becomes (k+1) mod 4. The pointer wraps from D to A. It does not change on cycles with no accept.

## Configuration
- `MUX_GATHER_RR_EN` defined:
  - Round-robin arbitration as above.
  - Search order starts at the pointer and wraps (e.g. pointer = 2 gives order C, D, A, B).
- Not defined:
  - Fixed priority A > B > C > D. No pointer register.
  - Channel D can starve while A stays valid.
- Handshake, latency and reset behaviour are identical in both modes.

## Structure
- Shared package `demux_pkg`:
  - Channel code constants `CH_A`=2'b00, `CH_B`=2'b01, `CH_C`=2'b10, `CH_D`=2'b11.
  - A `ch_t` 2-bit typedef.
  - Shared with the split side.
- Sub-module `rr_arbiter4`:
  - Inputs: 4-bit request, `advance`, `clk`, `rst`.
  - Outputs: one-hot grant and its 2-bit encoded index.
  - Holds the pointer in round-robin mode; purely combinational in fixed-priority mode.
- Top-level `mux_gather` holds the output register and the ready gating.

## Test plan
- Reset: hold `rst` for 2 cycles with all valids high -> all outputs 0, all readys 0. After release, the first accept is A with tag 00.
- Single channel: C offers 8'h5A with `out_ready` = 1 -> `c_ready` high 1 cycle. Next cycle `out_data` = 8'h5A, `out_sel` = 2'b10, `out_valid` = 1.
- Round-robin (RR_EN): all four channels valid continuously with `out_ready` = 1 -> tags 00, 01, 10, 11, 00, …, one per cycle, with no gaps.
- Fixed priority (no RR_EN): same stimulus -> tag 00 every cycle and `d_ready` never asserts.
- Backpressure: hold `out_ready` = 0 for 5 cycles with A = 8'h11 and B = 8'h22 valid -> one beat captured, outputs stable, all readys 0. After release, the beats drain back-to-back.
- Reset mid-stream: assert `rst` while `out_valid` = 1 and `out_data` = 8'hC3 -> the next cycle has `out_valid` = 0, `out_data` = 0, and the pointer back at A.
